// File: rtl/mips_pkg.sv
// Shared encodings, FSM states, ALU operations and instruction decode for the multicycle core.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [1:0] {
    StFetch,
    StDecode,
    StExecute,
    StWriteback
  } state_e;

  typedef enum logic [2:0] {
    AluAdd,
    AluSub,
    AluAnd,
    AluOr,
    AluSlt
  } alu_op_e;

  // Retirement behaviour class of a latched instruction
  typedef enum logic [2:0] {
    ClsAlu,
    ClsAddi,
    ClsBranch,
    ClsJr,
    ClsIllegal
  } instr_cls_e;

  typedef struct packed {
    instr_cls_e cls;
    alu_op_e    alu_op;
  } decode_t;

  // Map an instruction word to its class and ALU operation; anything unrecognised is illegal.
  function automatic decode_t decode_instr(input logic [31:0] ir);
    decode_t d;
    d.cls    = ClsIllegal;
    d.alu_op = AluAdd;
    case (ir[31:26])
      OpRtype: begin
        case (ir[5:0])
          FnAdd: begin d.cls = ClsAlu; d.alu_op = AluAdd; end
          FnSub: begin d.cls = ClsAlu; d.alu_op = AluSub; end
          FnAnd: begin d.cls = ClsAlu; d.alu_op = AluAnd; end
          FnOr:  begin d.cls = ClsAlu; d.alu_op = AluOr;  end
          FnSlt: begin d.cls = ClsAlu; d.alu_op = AluSlt; end
          FnJr:  d.cls = ClsJr;
          default: ;
        endcase
      end
      OpAddi: begin
        d.cls    = ClsAddi;
        d.alu_op = AluAdd;
      end
      OpBeq, OpBne: begin
        d.cls    = ClsBranch;
        d.alu_op = AluSub;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational XLEN-wide ALU: add, subtract, and, or, signed set-less-than.
module mips_alu
  import mips_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  // Select the operation result; arithmetic wraps modulo 2^XLEN
  always_comb begin
    y = '0;
    case (op)
      AluAdd:  y = a + b;
      AluSub:  y = a - b;
      AluAnd:  y = a & b;
      AluOr:   y = a | b;
      AluSlt:  y[0] = ($signed(a) < $signed(b));
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_multicycle_core.sv
// Four-state multicycle MIPS subset core with internal register file and debug read port.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREG     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  state_e state_q, state_d;

  logic [31:0]     ir_q;
  logic [XLEN-1:0] a_q, b_q, imm_q;
  logic [XLEN-1:0] alu_q;
  logic            taken_q;
  logic [XLEN-1:0] pc_q, result_q;
  logic            done_q, illegal_q;

  // Sized for the full 5-bit index space; entries at or above NREG are never written.
  logic [XLEN-1:0] regs_q [32];

  decode_t         dec;
  logic            accept;
  logic [XLEN-1:0] alu_b, alu_y;
  logic            alu_zero;
  logic [XLEN-1:0] pc_plus4;
  logic            wb_en;
  logic [4:0]      wb_idx;
  logic [XLEN-1:0] wb_data, pc_next, result_next;
  logic            illegal_next;
  logic            unused_shamt;

  // r0 and indices beyond the implemented set read as zero.
  function automatic logic [XLEN-1:0] reg_read(input logic [4:0] idx);
    logic [XLEN-1:0] v;
    v = '0;
    if (idx != 5'd0 && 32'(idx) < NREG) v = regs_q[idx];
    return v;
  endfunction

  assign dec          = decode_instr(ir_q);
  assign instr_ready  = (state_q == StFetch);
  assign accept       = instr_valid & instr_ready;
  assign unused_shamt = ^ir_q[10:6];

  assign alu_b = (dec.cls == ClsAddi) ? imm_q : b_q;

  mips_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .a    (a_q),
    .b    (alu_b),
    .op   (dec.alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // Next-state sequencing; only FETCH waits, the other states advance unconditionally
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:     if (accept) state_d = StDecode;
      StDecode:    state_d = StExecute;
      StExecute:   state_d = StWriteback;
      StWriteback: state_d = StFetch;
      default:     state_d = StFetch;
    endcase
  end

  // Retirement effects derived from the latched instruction and execute results
  always_comb begin
    pc_plus4     = pc_q + XLEN'(4);
    wb_en        = 1'b0;
    wb_idx       = ir_q[15:11];
    wb_data      = alu_q;
    pc_next      = pc_plus4;
    result_next  = alu_q;
    illegal_next = 1'b0;
    case (dec.cls)
      ClsAlu: begin
        wb_en  = 1'b1;
        wb_idx = ir_q[15:11];
      end
      ClsAddi: begin
        wb_en  = 1'b1;
        wb_idx = ir_q[20:16];
      end
      ClsBranch: begin
        if (taken_q) pc_next = pc_plus4 + (imm_q << 2);
      end
      ClsJr: begin
        pc_next     = a_q;
        result_next = a_q;
      end
      default: begin
        result_next  = pc_plus4;
        illegal_next = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // Datapath registers: each stage loads only in its own state, so late instr changes are ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_q     <= '0;
      taken_q   <= 1'b0;
      pc_q      <= PC_RESET;
      result_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        StFetch: begin
          if (accept) ir_q <= instr;
        end
        StDecode: begin
          a_q   <= reg_read(ir_q[25:21]);
          b_q   <= reg_read(ir_q[20:16]);
          imm_q <= XLEN'($signed(ir_q[15:0]));
        end
        StExecute: begin
          alu_q   <= alu_y;
          taken_q <= (ir_q[31:26] == OpBne) ? !alu_zero : alu_zero;
        end
        StWriteback: begin
          pc_q      <= pc_next;
          result_q  <= result_next;
          done_q    <= 1'b1;
          illegal_q <= illegal_next;
          if (wb_en && wb_idx != 5'd0 && 32'(wb_idx) < NREG) regs_q[wb_idx] <= wb_data;
        end
        default: ;
      endcase
    end
  end

  assign pc       = pc_q;
  assign result   = result_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign dbg_data = reg_read(dbg_addr);

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed self-checking bench; a 32-bit core and a 16-bit/8-register core run the same stream.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [4:0]  dbg_addr = '0;

  logic        instr_ready, done, illegal;
  logic [31:0] pc, result, dbg_data;
  logic        instr_ready16, done16, illegal16;
  logic [15:0] pc16, result16, dbg_data16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_core #(
    .XLEN(32), .NREG(32), .PC_RESET(32'h0)
  ) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .pc(pc), .result(result), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  mips_multicycle_core #(
    .XLEN(16), .NREG(8), .PC_RESET(16'h0)
  ) dut16 (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready16), .pc(pc16), .result(result16), .done(done16),
    .illegal(illegal16), .dbg_addr(dbg_addr), .dbg_data(dbg_data16)
  );

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  // Offer one instruction, accept at the next edge, then count edges until done (99 = timeout)
  task automatic run_instr(input logic [31:0] ins, output int lat);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 32'hFC00_FFFF;
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = 99;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (pc !== 32'h0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc_result: pc=%h result=%h, required 0/0", pc, result);
    end
    checks++;
    if (done !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: done=%b illegal=%b ready=%b, required 0/0/1",
               done, illegal, instr_ready);
    end
    checks++;
    if (dbg_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_r1: got %h, required 0", dbg_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addi();
    int lat;
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd5), lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL addi_latency: got %0d, required 3", lat);
    end
    checks++;
    if (result !== 32'd5 || pc !== 32'd4 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL addi_outputs: result=%h pc=%h illegal=%b, required 5/4/0",
               result, pc, illegal);
    end
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'd5) begin
      errors++;
      $display("FAIL addi_r1: got %h, required 5", dbg_data);
    end
  endtask

  task automatic test_slt();
    int lat;
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), lat);
    checks++;
    if (result !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL addi_neg: got %h, required fffffffd", result);
    end
    run_instr(enc_r(5'd2, 5'd1, 5'd3, 6'h2A), lat);
    dbg_addr = 5'd3;
    #1;
    checks++;
    if (dbg_data !== 32'd1 || result !== 32'd1) begin
      errors++;
      $display("FAIL slt_neg_lt_pos: r3=%h result=%h, required 1/1", dbg_data, result);
    end
    run_instr(enc_r(5'd1, 5'd2, 5'd6, 6'h2A), lat);
    checks++;
    if (result !== 32'd0 || pc !== 32'd16) begin
      errors++;
      $display("FAIL slt_pos_lt_neg: result=%h pc=%h, required 0/10", result, pc);
    end
  endtask

  task automatic test_alu_ops();
    int lat;
    logic [5:0]  fns [4];
    logic [4:0]  rds [4];
    logic [31:0] exps [4];
    fns = '{6'h22, 6'h24, 6'h25, 6'h20};
    rds = '{5'd4, 5'd7, 5'd8, 5'd9};
    exps = '{32'd8, 32'd5, 32'hFFFF_FFFD, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_instr(enc_r(5'd1, 5'd2, rds[i], fns[i]), lat);
      dbg_addr = rds[i];
      #1;
      checks++;
      if (dbg_data !== exps[i] || result !== exps[i]) begin
        errors++;
        $display("FAIL alu_op_%0d: reg=%h result=%h, required %h", i, dbg_data, result, exps[i]);
      end
    end
    checks++;
    if (pc !== 32'd32) begin
      errors++;
      $display("FAIL alu_pc: got %h, required 20", pc);
    end
  endtask

  task automatic test_xlen16();
    int lat;
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'hFFFF), lat);
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (result16 !== 16'hFFFF || dbg_data16 !== 16'hFFFF || result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL xlen16_neg1: r16=%h dbg16=%h r32=%h, required ffff/ffff/ffffffff",
               result16, dbg_data16, result);
    end
    run_instr(enc_i(6'h08, 5'd0, 5'd9, 16'd5), lat);
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (dbg_data !== 32'd5 || dbg_data16 !== 16'd0 || result16 !== 16'd5) begin
      errors++;
      $display("FAIL nreg_bound: r9=%h r9_16=%h res16=%h, required 5/0/5",
               dbg_data, dbg_data16, result16);
    end
  endtask

  task automatic test_r0_illegal();
    int lat;
    run_instr(enc_i(6'h08, 5'd0, 5'd0, 16'd7), lat);
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== 32'd0 || result !== 32'd7) begin
      errors++;
      $display("FAIL r0_write: r0=%h result=%h, required 0/7", dbg_data, result);
    end
    // pc is 44 here
    run_instr(enc_i(6'h3F, 5'd1, 5'd1, 16'd4), lat);
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (lat !== 3 || illegal !== 1'b1 || pc !== 32'd48 || result !== 32'd48) begin
      errors++;
      $display("FAIL illegal_op: lat=%0d illegal=%b pc=%h result=%h, required 3/1/30/30",
               lat, illegal, pc, result);
    end
    checks++;
    if (dbg_data !== 32'hFFFF_FFFF || illegal16 !== 1'b1 || pc16 !== 16'd48) begin
      errors++;
      $display("FAIL illegal_side: r1=%h ill16=%b pc16=%h, required ffffffff/1/30",
               dbg_data, illegal16, pc16);
    end
    run_instr(enc_r(5'd1, 5'd1, 5'd1, 6'h00), lat);
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (illegal !== 1'b1 || dbg_data !== 32'hFFFF_FFFF || result !== 32'd52) begin
      errors++;
      $display("FAIL illegal_funct: illegal=%b r1=%h result=%h, required 1/ffffffff/34",
               illegal, dbg_data, result);
    end
    run_instr(enc_i(6'h08, 5'd0, 5'd11, 16'd1), lat);
    checks++;
    if (illegal !== 1'b0 || pc !== 32'd56) begin
      errors++;
      $display("FAIL illegal_clear: illegal=%b pc=%h, required 0/38", illegal, pc);
    end
  endtask

  task automatic test_branch();
    int lat;
    do_reset();
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'h40), lat);
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'h40), lat);
    run_instr(enc_i(6'h04, 5'd1, 5'd2, 16'd3), lat);
    checks++;
    if (pc !== 32'd24 || result !== 32'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL beq_taken: pc=%h result=%h illegal=%b, required 18/0/0", pc, result, illegal);
    end
    do_reset();
    run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'h40), lat);
    run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'h40), lat);
    run_instr(enc_i(6'h05, 5'd1, 5'd2, 16'd3), lat);
    checks++;
    if (pc !== 32'd12) begin
      errors++;
      $display("FAIL bne_not_taken: pc=%h, required c", pc);
    end
    run_instr(enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE), lat);
    checks++;
    if (pc !== 32'd8 || result !== 32'h40) begin
      errors++;
      $display("FAIL bne_taken_back: pc=%h result=%h, required 8/40", pc, result);
    end
    run_instr(enc_i(6'h04, 5'd1, 5'd0, 16'd5), lat);
    checks++;
    if (pc !== 32'd12) begin
      errors++;
      $display("FAIL beq_not_taken: pc=%h, required c", pc);
    end
    run_instr({6'h00, 5'd1, 5'd0, 5'd5, 5'd0, 6'h08}, lat);
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (pc !== 32'h40 || result !== 32'h40 || dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL jr: pc=%h result=%h r5=%h, required 40/40/0", pc, result, dbg_data);
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    instr       = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1 || pc !== 32'h0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: ready=%b pc=%h done=%b result=%h, required 1/0/0/0",
               instr_ready, pc, done, result);
    end
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    dbg_addr = 5'd5;
    #1;
    checks++;
    if (ndone !== 0 || dbg_data !== 32'd0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: dones=%0d r5=%h pc=%h, required 0/0/0", ndone, dbg_data, pc);
    end
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: r1=%h, required 0", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    int naccept, ndone, first_acc, last_acc;
    naccept   = 0;
    ndone     = 0;
    first_acc = -1;
    last_acc  = -1;
    instr       = enc_i(6'h08, 5'd1, 5'd1, 16'd1);
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (instr_valid && instr_ready) begin
        naccept++;
        if (first_acc < 0) first_acc = i;
        last_acc = i;
      end
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    instr_valid = 1'b0;
    checks++;
    if (naccept !== 4 || ndone !== 4 || first_acc !== 0 || last_acc !== 12) begin
      errors++;
      $display("FAIL b2b_rate: accepts=%0d dones=%0d first=%0d last=%0d, required 4/4/0/12",
               naccept, ndone, first_acc, last_acc);
    end
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'd4 || pc !== 32'd16) begin
      errors++;
      $display("FAIL b2b_state: r1=%h pc=%h, required 4/10", dbg_data, pc);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_slt();
    test_alu_ops();
    test_xlen16();
    test_r0_illegal();
    test_branch();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
